nbit_alu: RTL and testbench
===========================

Name: nbit_alu

Overview:
- Parameterised N-bit, 8-operation ALU: add and subtract with carry-in, AND, OR, XOR, complement, increment and decrement.
- Result and carry/borrow flag are registered, so the block drops into a synchronous datapath as a single pipeline stage.
- Operands and opcode are driven combinationally by the surrounding datapath or controller.

Parameters:
- N, 4, operand/result width in bits (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A.
- B  input  N  operand B; ignored by modes 101, 110 and 111.
- mode  input  3  operation select.
- carry_in  input  1  carry (add) or borrow (subtract) input; ignored by all other modes.
- Y  output  N  registered result.
- carry_out  output  1  registered carry/borrow flag.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high. On a rising clk edge with rst=1, Y <= 0 and carry_out <= 0.
  - Reset has priority over any operation; asserting rst mid-stream discards that cycle's result.
- Latency:
  - Inputs are sampled on each rising clk edge with rst=0.
  - Y and carry_out reflect that sample from the edge onward, i.e. exactly 1-cycle latency.
  - Throughput is one operation per cycle. There is no handshake; outputs hold until the next edge.
- Arithmetic is unsigned, modulo 2^N; carry_out carries the (N+1)th bit.
- Mode encoding:
  - 000 ADD: {carry_out,Y} = A + B + carry_in.
  - 001 SUB: Y = (A - B - carry_in) mod 2^N. carry_out = borrow, i.e. 1 iff A < B + carry_in.
  - 010 AND: Y = A & B; carry_out = 0.
  - 011 OR: Y = A | B; carry_out = 0.
  - 100 XOR: Y = A ^ B; carry_out = 0.
  - 101 COMPLEMENT: Y = ~A; carry_out = 0.
  - 110 INCREMENT: {carry_out,Y} = A + 1. All-ones wraps to 0 with carry_out = 1.
  - 111 DECREMENT: Y = (A - 1) mod 2^N. carry_out = borrow, i.e. 1 iff A == 0; zero wraps to all-ones.
- Boundaries:
  - Max + max + 1 on ADD yields Y = all-ones with carry_out = 1.
  - SUB with A == B and carry_in = 0 yields Y = 0, carry_out = 0.
  - SUB with A == B and carry_in = 1 yields Y = all-ones, carry_out = 1.
- All 8 mode codes are defined; there is no illegal-opcode state.
- There is no internal state beyond the two output registers.

Decomposition:
- Shared package alu_pkg: the eight 3-bit opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_DEC).
- One sub-module, nbit_adder:
  - Parameterised N-bit ripple adder with cin/cout.
  - ADD, SUB (via A + ~B with inverted-borrow handling), INC and DEC are all built on it.
- The top level holds the opcode mux and the output registers.

Test Plan (N=4; check outputs one cycle after applying inputs):
- Reset: assert rst for 2 cycles with arbitrary inputs -> Y=0000, carry_out=0; deassert and apply ADD 0011+0101, cin=0 -> Y=1000, carry_out=0 on the next edge.
- ADD carry: A=1111, B=0001, cin=1 -> Y=0001, carry_out=1.
- ADD, no carry: A=1000, B=0110, cin=0 -> Y=1110, carry_out=0.
- SUB:
  - A=0101, B=0011, cin=0 -> Y=0010, carry_out=0.
  - A=0001, B=0010, cin=1 -> Y=1110, carry_out=1 (borrow).
- Logic and complement:
  - AND 1100/1010 -> 1000.
  - OR 0000/0000 -> 0000.
  - XOR 1111/1111 -> 0000.
  - COMPLEMENT 1010 -> 0101.
  - carry_out=0 throughout, with cin held at 1 to prove it is ignored.
- INC/DEC wrap:
  - INC 1111 -> Y=0000, carry_out=1.
  - INC 1000 -> 1001, carry_out=0.
  - DEC 0000 -> Y=1111, carry_out=1.
  - DEC 0010 -> 0001, carry_out=0.
- Reset mid-stream: issue back-to-back ops, assert rst on one edge -> outputs 0 on that edge; the operation presented in that cycle is lost; the next op resumes with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants for the N-bit ALU and its consumers.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

endpackage : alu_pkg

// File: rtl/nbit_adder.sv
// Parameterised N-bit ripple-carry adder: {cout, sum} = a + b + cin.
module nbit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum[gi]          = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1]  = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[N];

endmodule : nbit_adder

// File: rtl/nbit_alu.sv
// N-bit, 8-operation ALU with a single registered output stage.
// Every arithmetic mode shares one adder; subtraction and decrement add the
// one's complement and report borrow as the inverted adder carry.
module nbit_alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   mode,
  input  logic         carry_in,
  output logic [N-1:0] Y,
  output logic         carry_out
);

  logic [N-1:0] w_add_b;
  logic         w_add_cin;
  logic [N-1:0] w_add_sum;
  logic         w_add_cout;
  logic [N-1:0] w_y_next;
  logic         w_co_next;
  logic [N-1:0] r_y;
  logic         r_co;

  // Select the adder's second operand and carry input for the current mode.
  always_comb begin
    w_add_b   = B;
    w_add_cin = carry_in;
    case (mode)
      OP_ADD: begin
        w_add_b   = B;
        w_add_cin = carry_in;
      end
      OP_SUB: begin
        // A - B - bin == A + ~B + ~bin (mod 2^N)
        w_add_b   = ~B;
        w_add_cin = ~carry_in;
      end
      OP_INC: begin
        w_add_b   = {N{1'b0}};
        w_add_cin = 1'b1;
      end
      OP_DEC: begin
        w_add_b   = {N{1'b1}};
        w_add_cin = 1'b0;
      end
      default: begin
        w_add_b   = B;
        w_add_cin = carry_in;
      end
    endcase
  end

  nbit_adder #(.N(N)) u_adder (
    .a    (A),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  // Choose the next result and flag; borrow modes invert the adder carry.
  always_comb begin
    w_y_next  = {N{1'b0}};
    w_co_next = 1'b0;
    case (mode)
      OP_ADD: begin
        w_y_next  = w_add_sum;
        w_co_next = w_add_cout;
      end
      OP_SUB: begin
        w_y_next  = w_add_sum;
        w_co_next = ~w_add_cout;
      end
      OP_AND: begin
        w_y_next  = A & B;
        w_co_next = 1'b0;
      end
      OP_OR: begin
        w_y_next  = A | B;
        w_co_next = 1'b0;
      end
      OP_XOR: begin
        w_y_next  = A ^ B;
        w_co_next = 1'b0;
      end
      OP_NOT: begin
        w_y_next  = ~A;
        w_co_next = 1'b0;
      end
      OP_INC: begin
        w_y_next  = w_add_sum;
        w_co_next = w_add_cout;
      end
      OP_DEC: begin
        w_y_next  = w_add_sum;
        w_co_next = ~w_add_cout;
      end
      default: begin
        w_y_next  = {N{1'b0}};
        w_co_next = 1'b0;
      end
    endcase
  end

  // Output pipeline register; synchronous reset overrides the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y  <= {N{1'b0}};
      r_co <= 1'b0;
    end else begin
      r_y  <= w_y_next;
      r_co <= w_co_next;
    end
  end

  assign Y         = r_y;
  assign carry_out = r_co;

endmodule : nbit_alu

// File: tb/tb_nbit_alu.sv
// Directed self-checking bench for nbit_alu with N=4.
module tb_nbit_alu;
  import alu_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   mode;
  logic         carry_in;
  logic [N-1:0] Y;
  logic         carry_out;

  int errors = 0;
  int checks = 0;

  nbit_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .carry_in  (carry_in),
    .Y         (Y),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one set of inputs, clock it in, then check outputs #1 after the edge.
  task automatic step(input string tag, input logic r, input logic [2:0] m,
                      input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                      input logic [N-1:0] exp_y, input logic exp_co);
    rst      = r;
    mode     = m;
    A        = a;
    B        = b;
    carry_in = ci;
    @(posedge clk);
    #1;
    checks++;
    assert (Y === exp_y) else begin
      errors++;
      $error("FAIL %s Y: got %b expected %b", tag, Y, exp_y);
    end
    checks++;
    assert (carry_out === exp_co) else begin
      errors++;
      $error("FAIL %s carry_out: got %b expected %b", tag, carry_out, exp_co);
    end
  endtask

  initial begin
    rst = 1'b1; mode = OP_ADD; A = 4'b0000; B = 4'b0000; carry_in = 1'b0;
    #2;

    // Reset for two cycles with arbitrary inputs
    step("rst1", 1'b1, OP_ADD, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("rst2", 1'b1, OP_INC, 4'b1111, 4'b0101, 1'b1, 4'b0000, 1'b0);
    step("add_first", 1'b0, OP_ADD, 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0);

    // ADD
    step("add_carry",  1'b0, OP_ADD, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);
    step("add_nocar",  1'b0, OP_ADD, 4'b1000, 4'b0110, 1'b0, 4'b1110, 1'b0);
    step("add_maxmax", 1'b0, OP_ADD, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

    // SUB
    step("sub_basic",  1'b0, OP_SUB, 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0);
    step("sub_borrow", 1'b0, OP_SUB, 4'b0001, 4'b0010, 1'b1, 4'b1110, 1'b1);
    step("sub_eq_c0",  1'b0, OP_SUB, 4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0);
    step("sub_eq_c1",  1'b0, OP_SUB, 4'b0110, 4'b0110, 1'b1, 4'b1111, 1'b1);

    // Logic and complement, carry_in held high to show it is ignored
    step("and",  1'b0, OP_AND, 4'b1100, 4'b1010, 1'b1, 4'b1000, 1'b0);
    step("or",   1'b0, OP_OR,  4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    step("or2",  1'b0, OP_OR,  4'b1100, 4'b0011, 1'b1, 4'b1111, 1'b0);
    step("xor",  1'b0, OP_XOR, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
    step("xor2", 1'b0, OP_XOR, 4'b1100, 4'b1010, 1'b1, 4'b0110, 1'b0);
    step("not",  1'b0, OP_NOT, 4'b1010, 4'b1111, 1'b1, 4'b0101, 1'b0);

    // INC / DEC, with B and carry_in set to junk
    step("inc_wrap", 1'b0, OP_INC, 4'b1111, 4'b1010, 1'b1, 4'b0000, 1'b1);
    step("inc",      1'b0, OP_INC, 4'b1000, 4'b0111, 1'b1, 4'b1001, 1'b0);
    step("dec_wrap", 1'b0, OP_DEC, 4'b0000, 4'b0101, 1'b1, 4'b1111, 1'b1);
    step("dec",      1'b0, OP_DEC, 4'b0010, 4'b1111, 1'b1, 4'b0001, 1'b0);

    // Reset mid-stream: the op presented with rst is lost
    step("ms_pre",  1'b0, OP_ADD, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
    step("ms_rst",  1'b1, OP_INC, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("ms_post", 1'b0, OP_SUB, 4'b0011, 4'b0100, 1'b0, 4'b1111, 1'b1);
    step("ms_next", 1'b0, OP_NOT, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nbit_alu
